// File: rtl/sprite_bank_arbiter_if.sv
// Bus bundle for the sprite bank arbiter: print-path read port, CPU write port,
// FIFO occupancy and the single-port bank strobe/data lines.
interface sprite_bank_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 3
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;

   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic [CNT_W-1:0]  fifo_count;

   logic              bank_en;
   logic              bank_we;
   logic [ADDR_W-1:0] bank_addr;
   logic [DATA_W-1:0] bank_wdata;
   logic [DATA_W-1:0] bank_rdata;

   modport slave (
      input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, bank_rdata,
      output rd_ready, rd_valid, rd_data, wr_ready, fifo_count,
             bank_en, bank_we, bank_addr, bank_wdata
   );

   modport master (
      output rd_req, rd_addr, wr_valid, wr_addr, wr_data, bank_rdata,
      input  rd_ready, rd_valid, rd_data, wr_ready, fifo_count,
             bank_en, bank_we, bank_addr, bank_wdata
   );
endinterface

// File: rtl/sprite_bank_arbiter.sv
// Shares the single-port sprite register bank between the scan-out read path
// (priority) and CPU writes buffered in a small FIFO with a starvation guard.
module sprite_bank_arbiter #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_WAIT   = 15
) (
   input logic                  clk,
   input logic                  reset,
   sprite_bank_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, FORCE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wptr_q, rptr_q, offs;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic              bank_en_q, bank_we_q, rd_valid_q;
   logic [ADDR_W-1:0] bank_addr_q;
   logic [DATA_W-1:0] bank_wdata_q, rd_data_q;
   logic              fifo_empty, hazard, force_wr, rd_ready, rd_fire, pop, push;

   // An entry is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      hazard = 1'b0;
      offs   = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         offs = PTR_W'(i) - rptr_q;
         if (({1'b0, offs} < count_q) && (fifo_addr_q[i] == bus.rd_addr))
            hazard = 1'b1;
      end
      hazard = hazard && bus.rd_req;
   end

   always_comb begin
      fifo_empty = (count_q == '0);
      force_wr   = (starve_q == STV_W'(MAX_WAIT)) && !fifo_empty;
      rd_ready   = !hazard && !force_wr;
      rd_fire    = bus.rd_req && rd_ready;
      pop        = !fifo_empty && !rd_fire;
      push       = bus.wr_valid && (count_q < CNT_W'(FIFO_DEPTH));
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

      state_d = IDLE;
      if (rd_fire)
         state_d = READ;
      else if (pop && force_wr)
         state_d = FORCE;
      else if (pop)
         state_d = WRITE;

      starve_d = starve_q;
      if (pop || fifo_empty)
         starve_d = '0;
      else if (rd_fire && (starve_q != STV_W'(MAX_WAIT)))
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wptr_q] <= bus.wr_addr;
         fifo_data_q[wptr_q] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         starve_q     <= '0;
         bank_en_q    <= 1'b0;
         bank_we_q    <= 1'b0;
         bank_addr_q  <= '0;
         bank_wdata_q <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;

         bank_en_q <= rd_fire || pop;
         bank_we_q <= pop;
         if (rd_fire) begin
            bank_addr_q <= bus.rd_addr;
         end else if (pop) begin
            bank_addr_q  <= fifo_addr_q[rptr_q];
            bank_wdata_q <= fifo_data_q[rptr_q];
         end

         // A READ grant last cycle means the bank is presenting that word now.
         rd_valid_q <= (state_q == READ);
         if (state_q == READ)
            rd_data_q <= bus.bank_rdata;
      end
   end

   assign bus.rd_ready   = rd_ready && !reset;
   assign bus.wr_ready   = (count_q < CNT_W'(FIFO_DEPTH)) && !reset;
   assign bus.fifo_count = count_q;
   assign bus.bank_en    = bank_en_q;
   assign bus.bank_we    = bank_we_q;
   assign bus.bank_addr  = bank_addr_q;
   assign bus.bank_wdata = bank_wdata_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_data    = rd_data_q;
endmodule
